// File: rtl/keypad_pkg.sv
// Shared types and key-code constants for the keypad entry path.
package keypad_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDebounce,
        StHeld
    } key_state_e;

    localparam logic [3:0] KEY_NONE      = 4'hF;
    localparam logic [3:0] KEY_CLEAR     = 4'hC;
    localparam logic [3:0] KEY_BACKSPACE = 4'hE;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// Key input and entry/command outputs of keypad_entry, bundled for the display and control side.
interface keypad_entry_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    localparam int unsigned COUNT_W = $clog2(NUM_DIGITS + 1);

    logic [3:0]              key_code;
    logic                    key_valid;
    logic [3:0]              key_value;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [COUNT_W-1:0]      digit_count;
    logic                    cmd_valid;
    logic [3:0]              cmd_code;
    logic                    overflow;

    modport master (
        output key_code,
        input  key_valid, key_value, digits, digit_count, cmd_valid, cmd_code, overflow
    );

    modport slave (
        input  key_code,
        output key_valid, key_value, digits, digit_count, cmd_valid, cmd_code, overflow
    );
endinterface

// File: rtl/key_debounce.sv
// Press/release debouncer: turns each stable keypad press into one key_valid pulse.
module key_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned PRESS_CYCLES   = 200000,
    parameter int unsigned RELEASE_CYCLES = 2100000
) (
    input  logic       clock_100Mhz,
    input  logic       rst_n,
    input  logic [3:0] key_code,
    output logic       key_valid,
    output logic [3:0] key_value
);
    localparam int unsigned MAX_CYCLES = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES
                                                                         : RELEASE_CYCLES;
    localparam int unsigned CNT_W = $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0] PRESS_LAST   = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);

    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cand_q, cand_d;
    logic             key_valid_q, key_valid_d;
    logic [3:0]       key_value_q, key_value_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_valid_d = 1'b0;
        key_value_d = key_value_q;
        case (state_q)
            StIdle: begin
                if (key_code != KEY_NONE) begin
                    state_d = StDebounce;
                    cand_d  = key_code;
                    cnt_d   = CNT_W'(1);
                end
            end
            StDebounce: begin
                if (key_code == KEY_NONE) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (key_code == cand_q) begin
                    if (cnt_q == PRESS_LAST) begin
                        state_d     = StHeld;
                        cnt_d       = '0;
                        key_valid_d = 1'b1;
                        key_value_d = cand_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cand_d = key_code;
                    cnt_d  = CNT_W'(1);
                end
            end
            StHeld: begin
                // Any key sample, including another key, restarts the release window.
                if (key_code == KEY_NONE) begin
                    if (cnt_q == RELEASE_LAST) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_100Mhz) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            cand_q      <= KEY_NONE;
            key_valid_q <= 1'b0;
            key_value_q <= KEY_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_valid_q <= key_valid_d;
            key_value_q <= key_value_d;
        end
    end

    assign key_valid = key_valid_q;
    assign key_value = key_value_q;
endmodule

// File: rtl/keypad_entry.sv
// Keypad front end: debounced key events, BCD entry register and command decode.
// Define KEYPAD_ENTRY_BACKSPACE_EN to make key E a backspace instead of a command.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int unsigned PRESS_CYCLES   = 200000,
    parameter int unsigned RELEASE_CYCLES = 2100000,
    parameter int unsigned NUM_DIGITS     = 4
) (
    input logic           clock_100Mhz,
    input logic           rst_n,
    keypad_entry_if.slave kif
);
    localparam int unsigned DW      = 4 * NUM_DIGITS;
    localparam int unsigned COUNT_W = $clog2(NUM_DIGITS + 1);

    logic               key_valid;
    logic [3:0]         key_value;
    logic [DW-1:0]      digits_q, digits_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic [3:0]         cmd_code_q, cmd_code_d;
    logic               overflow_q, overflow_d;

    key_debounce #(
        .PRESS_CYCLES   (PRESS_CYCLES),
        .RELEASE_CYCLES (RELEASE_CYCLES)
    ) u_debounce (
        .clock_100Mhz (clock_100Mhz),
        .rst_n        (rst_n),
        .key_code     (kif.key_code),
        .key_valid    (key_valid),
        .key_value    (key_value)
    );

    always_comb begin
        digits_d    = digits_q;
        count_d     = count_q;
        cmd_valid_d = 1'b0;
        cmd_code_d  = cmd_code_q;
        overflow_d  = 1'b0;
        if (key_valid) begin
            if (is_digit(key_value)) begin
                if (count_q < COUNT_W'(NUM_DIGITS)) begin
                    digits_d = (digits_q << 4) | DW'(key_value);
                    count_d  = count_q + COUNT_W'(1);
                end else begin
                    overflow_d = 1'b1;
                end
            end else if (key_value == KEY_CLEAR) begin
                digits_d = '0;
                count_d  = '0;
            end
`ifdef KEYPAD_ENTRY_BACKSPACE_EN
            else if (key_value == KEY_BACKSPACE) begin
                if (count_q != '0) begin
                    digits_d = digits_q >> 4;
                    count_d  = count_q - COUNT_W'(1);
                end
            end
`endif
            else begin
                cmd_valid_d = 1'b1;
                cmd_code_d  = key_value;
            end
        end
    end

    always_ff @(posedge clock_100Mhz) begin
        if (!rst_n) begin
            digits_q    <= '0;
            count_q     <= '0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= 4'h0;
            overflow_q  <= 1'b0;
        end else begin
            digits_q    <= digits_d;
            count_q     <= count_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            overflow_q  <= overflow_d;
        end
    end

    assign kif.key_valid   = key_valid;
    assign kif.key_value   = key_value;
    assign kif.digits      = digits_q;
    assign kif.digit_count = count_q;
    assign kif.cmd_valid   = cmd_valid_q;
    assign kif.cmd_code    = cmd_code_q;
    assign kif.overflow    = overflow_q;
endmodule

// File: tb/tb_keypad_entry.sv
// Directed self-checking bench for keypad_entry with short debounce windows.
module tb_keypad_entry;
    localparam int unsigned PRESS_CYCLES   = 4;
    localparam int unsigned RELEASE_CYCLES = 8;
    localparam int unsigned NUM_DIGITS     = 4;

    logic clock_100Mhz = 1'b0;
    logic rst_n        = 1'b0;

    always #5 clock_100Mhz = ~clock_100Mhz;

    keypad_entry_if #(.NUM_DIGITS(NUM_DIGITS)) kif ();

    keypad_entry #(
        .PRESS_CYCLES   (PRESS_CYCLES),
        .RELEASE_CYCLES (RELEASE_CYCLES),
        .NUM_DIGITS     (NUM_DIGITS)
    ) dut (
        .clock_100Mhz (clock_100Mhz),
        .rst_n        (rst_n),
        .kif          (kif)
    );

    int checks = 0;
    int errors = 0;
    int n_key  = 0;
    int n_cmd  = 0;
    int n_ovf  = 0;

    // Pulse counters sampled mid-cycle.
    always @(negedge clock_100Mhz) begin
        if (kif.key_valid === 1'b1) n_key = n_key + 1;
        if (kif.cmd_valid === 1'b1) n_cmd = n_cmd + 1;
        if (kif.overflow === 1'b1)  n_ovf = n_ovf + 1;
    end

    task automatic tick();
        @(posedge clock_100Mhz);
        #1;
    endtask

    task automatic drive(input logic [3:0] code, input int cycles);
        kif.key_code = code;
        repeat (cycles) tick();
    endtask

    task automatic press(input logic [3:0] code);
        drive(code, PRESS_CYCLES);
        drive(4'hF, RELEASE_CYCLES);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        kif.key_code = 4'hF;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        kif.key_code = 4'h5;
        repeat (3) tick();
        checks++;
        if (kif.key_valid !== 1'b0) begin
            errors++; $display("FAIL reset_key_valid got %b want 0", kif.key_valid);
        end
        checks++;
        if (kif.key_value !== 4'hF) begin
            errors++; $display("FAIL reset_key_value got %h want f", kif.key_value);
        end
        checks++;
        if (kif.digits !== 16'h0000 || kif.digit_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_entry got %h/%0d want 0000/0", kif.digits, kif.digit_count);
        end
        checks++;
        if (kif.cmd_valid !== 1'b0 || kif.cmd_code !== 4'h0 || kif.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_cmd got %b/%h/%b want 0/0/0", kif.cmd_valid, kif.cmd_code,
                     kif.overflow);
        end
        // Key held through reset release must be debounced afresh.
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (kif.key_valid !== 1'b0) begin
                errors++; $display("FAIL reset_held_early cycle %0d got %b want 0", i,
                                   kif.key_valid);
            end
        end
        tick();
        checks++;
        if (kif.key_valid !== 1'b1 || kif.key_value !== 4'h5) begin
            errors++; $display("FAIL reset_redebounce got %b/%h want 1/5", kif.key_valid,
                               kif.key_value);
        end
        // Reset while held clears the captured value.
        rst_n = 1'b0;
        tick();
        checks++;
        if (kif.key_value !== 4'hF || kif.digits !== 16'h0000) begin
            errors++; $display("FAIL reset_while_held got %h/%h want f/0000", kif.key_value,
                               kif.digits);
        end
    endtask

    task automatic test_press_release();
        int k0;
        do_reset();
        k0 = n_key;
        drive(4'h7, PRESS_CYCLES);
        checks++;
        if (kif.key_valid !== 1'b1 || kif.key_value !== 4'h7 || kif.digits !== 16'h0000) begin
            errors++; $display("FAIL press_latency got %b/%h/%h want 1/7/0000", kif.key_valid,
                               kif.key_value, kif.digits);
        end
        drive(4'hF, 1);
        checks++;
        if (kif.key_valid !== 1'b0 || kif.digits !== 16'h0007 || kif.digit_count !== 3'd1) begin
            errors++; $display("FAIL press_entry got %b/%h/%0d want 0/0007/1", kif.key_valid,
                               kif.digits, kif.digit_count);
        end
        drive(4'hF, RELEASE_CYCLES - 1);
        checks++;
        if (n_key - k0 !== 1) begin
            errors++; $display("FAIL press_count got %0d want 1", n_key - k0);
        end
    endtask

    task automatic test_bounce();
        int k0;
        do_reset();
        k0 = n_key;
        drive(4'h3, 2);
        drive(4'hF, 1);
        drive(4'h3, 3);
        checks++;
        if (kif.key_valid !== 1'b0 || n_key !== k0) begin
            errors++; $display("FAIL bounce_early got %b/%0d want 0/0", kif.key_valid,
                               n_key - k0);
        end
        drive(4'h3, 1);
        checks++;
        if (kif.key_valid !== 1'b1 || kif.key_value !== 4'h3) begin
            errors++; $display("FAIL bounce_accept got %b/%h want 1/3", kif.key_valid,
                               kif.key_value);
        end
        drive(4'hF, RELEASE_CYCLES);
        checks++;
        if (n_key - k0 !== 1 || kif.digits !== 16'h0003) begin
            errors++; $display("FAIL bounce_single got %0d/%h want 1/0003", n_key - k0,
                               kif.digits);
        end
    endtask

    task automatic test_scan_gaps();
        int k0;
        do_reset();
        k0 = n_key;
        drive(4'h2, PRESS_CYCLES);
        for (int i = 0; i < 5; i++) begin
            drive(4'h2, 2);
            drive(4'hF, 6);
        end
        checks++;
        if (n_key - k0 !== 1) begin
            errors++; $display("FAIL scan_gaps_count got %0d want 1", n_key - k0);
        end
        drive(4'hF, RELEASE_CYCLES);
        press(4'h6);
        checks++;
        if (n_key - k0 !== 2 || kif.digits !== 16'h0026) begin
            errors++; $display("FAIL scan_gaps_release got %0d/%h want 2/0026", n_key - k0,
                               kif.digits);
        end
    endtask

    task automatic test_entry();
        int o0;
        int c0;
        do_reset();
        o0 = n_ovf;
        c0 = n_cmd;
        press(4'h1);
        press(4'h2);
        press(4'h3);
        press(4'h4);
        checks++;
        if (kif.digits !== 16'h1234 || kif.digit_count !== 3'd4 || n_ovf !== o0) begin
            errors++; $display("FAIL entry_full got %h/%0d/%0d want 1234/4/0", kif.digits,
                               kif.digit_count, n_ovf - o0);
        end
        press(4'h5);
        checks++;
        if (kif.digits !== 16'h1234 || kif.digit_count !== 3'd4 || n_ovf - o0 !== 1) begin
            errors++; $display("FAIL entry_overflow got %h/%0d/%0d want 1234/4/1", kif.digits,
                               kif.digit_count, n_ovf - o0);
        end
        press(4'hC);
        checks++;
        if (kif.digits !== 16'h0000 || kif.digit_count !== 3'd0 || n_cmd !== c0) begin
            errors++; $display("FAIL entry_clear got %h/%0d/%0d want 0000/0/0", kif.digits,
                               kif.digit_count, n_cmd - c0);
        end
    endtask

    task automatic test_command();
        int c0;
        do_reset();
        c0 = n_cmd;
        drive(4'hA, PRESS_CYCLES);
        checks++;
        if (kif.cmd_valid !== 1'b0) begin
            errors++; $display("FAIL cmd_early got %b want 0", kif.cmd_valid);
        end
        drive(4'hF, 1);
        checks++;
        if (kif.cmd_valid !== 1'b1 || kif.cmd_code !== 4'hA || kif.digits !== 16'h0000) begin
            errors++; $display("FAIL cmd_a got %b/%h/%h want 1/a/0000", kif.cmd_valid,
                               kif.cmd_code, kif.digits);
        end
        drive(4'hF, RELEASE_CYCLES - 1);
        press(4'h9);
        press(4'h8);
        press(4'hE);
`ifdef KEYPAD_ENTRY_BACKSPACE_EN
        checks++;
        if (kif.digits !== 16'h0009 || kif.digit_count !== 3'd1 || n_cmd - c0 !== 1) begin
            errors++; $display("FAIL cmd_backspace got %h/%0d/%0d want 0009/1/1", kif.digits,
                               kif.digit_count, n_cmd - c0);
        end
        press(4'hE);
        press(4'hE);
        checks++;
        if (kif.digits !== 16'h0000 || kif.digit_count !== 3'd0) begin
            errors++; $display("FAIL cmd_backspace_empty got %h/%0d want 0000/0", kif.digits,
                               kif.digit_count);
        end
`else
        checks++;
        if (kif.digits !== 16'h0098 || kif.cmd_code !== 4'hE || n_cmd - c0 !== 2) begin
            errors++; $display("FAIL cmd_e got %h/%h/%0d want 0098/e/2", kif.digits,
                               kif.cmd_code, n_cmd - c0);
        end
`endif
        press(4'hD);
        checks++;
        if (kif.cmd_code !== 4'hD) begin
            errors++; $display("FAIL cmd_d got %h want d", kif.cmd_code);
        end
    endtask

    initial begin
        kif.key_code = 4'hF;
        test_reset();
        test_press_release();
        test_bounce();
        test_scan_gaps();
        test_entry();
        test_command();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/keypad_entry.md
# keypad_entry

Debounces the 4-bit key code produced by the keypad column-scan decoder and turns each physical press into one single-cycle key event. Decimal keys (0–9) accumulate into a right-justified BCD entry register for the 7-segment display path. Command keys (A, B, D) are forwarded as command pulses; C clears the entry. Sits directly downstream of the decoder; its outputs feed the display and control logic.

## Interface
- PRESS_CYCLES, 200000: consecutive identical non-F samples required to accept a press. Must be less than 2^18, because the decoder presents a key only during its own column slot.
- RELEASE_CYCLES, 2100000: consecutive 4'hF samples required to accept a release. Must exceed the full 2^20-cycle scan period.
- NUM_DIGITS, 4: entry register depth in BCD digits, minimum 1.
- clock_100Mhz  in  1  system clock, 100 MHz
- rst_n  in  1  synchronous, active-low reset
- key_code  in  4  decoder output; 4'hF means no key
- key_valid  out  1  one-cycle pulse per accepted press
- key_value  out  4  code of the last accepted press
- digits  out  4*NUM_DIGITS  BCD entry; the newest digit is in bits [3:0]
- digit_count  out  $clog2(NUM_DIGITS+1)  number of digits entered
- cmd_valid  out  1  one-cycle pulse for a command key
- cmd_code  out  4  command key code
- overflow  out  1  one-cycle pulse when a digit is rejected because the entry is full

## Operation
- Key F is indistinguishable from "no key" and can never be entered.
- The FSM has three states: IDLE, DEBOUNCE, HELD. A candidate register `cand` holds the key being tracked; a shared counter `cnt` is sized by $clog2 of max(PRESS_CYCLES, RELEASE_CYCLES).
- IDLE:
  - key_code ≠ F → DEBOUNCE, cand=key_code, cnt=1.
- DEBOUNCE:
  - key_code == cand and cnt == PRESS_CYCLES-1 → HELD, cnt=0, key_valid=1, key_value=cand.
  - key_code == cand otherwise → cnt+1.
  - key_code == F → IDLE.
  - key_code is a different non-F code → stay in DEBOUNCE, cand=new code, cnt=1.
- HELD:
  - key_code == F → cnt+1. On reaching RELEASE_CYCLES-1 → IDLE.
  - Any non-F code → cnt=0. There is no rollover: a second key pressed while one is held is ignored, and there is no auto-repeat.
- Entry update on the edge where key_valid=1:
  - Digit 0–9 with digit_count < NUM_DIGITS → digits shift left one nibble, new digit enters at [3:0], digit_count+1.
  - Digit 0–9 with the entry full → digits unchanged, overflow=1.
  - C → digits=0, digit_count=0.
  - A, B, D → cmd_valid=1, cmd_code=value.
  - E → see Configuration.

## Timing
- Reset values: state IDLE, cnt 0, cand 4'hF, key_valid 0, key_value 4'hF, digits 0, digit_count 0, cmd_valid 0, cmd_code 0, overflow 0.
- Press latency: key_valid is high in the cycle after the PRESS_CYCLES-th consecutive matching sample.
- Entry latency: digits, digit_count, cmd_valid and overflow update one cycle after key_valid.
- Minimum interval between two key_valid pulses is PRESS_CYCLES + RELEASE_CYCLES cycles.
- rst_n low at any point, including mid-debounce or while a key is held, returns every register to its reset value on the next edge. A key still held when reset is released must be re-debounced before it produces an event.

## Configuration
- KEYPAD_ENTRY_BACKSPACE_EN defined: E is backspace.
  - digit_count > 0 → digits shift right one nibble (zero fill at the top), digit_count-1, no cmd_valid.
  - digit_count == 0 → no effect.
- Not defined: E is a command key (cmd_valid=1, cmd_code=4'hE).

## Structure
- Shared package keypad_pkg holds:
  - the FSM state enum
  - KEY_NONE=4'hF, KEY_CLEAR=4'hC, KEY_BACKSPACE=4'hE
- Sub-module key_debounce contains the FSM and counter, and produces key_valid/key_value. The keypad_entry top holds the entry register and command decode.

## Test plan
All scenarios use PRESS_CYCLES=4, RELEASE_CYCLES=8, NUM_DIGITS=4.
- Reset: hold rst_n=0 with key_code=5 → all outputs at reset values; key_valid stays 0 for 3 cycles after release of reset.
- Press and release: key_code=7 for 4 cycles, then F for 8 cycles → exactly one key_valid with key_value=7; digits=16'h0007, digit_count=1.
- Bounce: key_code 3,3,F,3,3,3,3 → only the final run of four 3s yields key_valid; result is a single event.
- Scan gaps: key_code=2 for 4 cycles, then alternating 2 for 2 cycles / F for 6 cycles, for 40 cycles → exactly one key_valid.
- Entry sequence: press 1,2,3,4,5 → digits=16'h1234 with overflow pulse on the 5th press; then press C → digits=0, digit_count=0.
- Command and backspace: press A → cmd_valid=1, cmd_code=4'hA, digits unchanged. Press 9,8 then E → digits=16'h0009 with KEYPAD_ENTRY_BACKSPACE_EN defined, or cmd_code=4'hE and digits=16'h0098 without it.
